// File: rtl/aes_block_sequencer.sv
// Sequencer between a 32-bit host stream and a 128-bit AES core: gathers four
// words, starts the core, guards it with a wait timer and streams the result back.
//
// state  | meaning
// LOAD   | accepting host words into the block register
// START  | one-cycle start pulse to the core, wait timer cleared
// WAIT   | core computing; timer runs until completion or timeout
// UNLOAD | result words handed to the host, one per handshake
module aes_block_sequencer #(
   parameter int unsigned TIMEOUT_CYC     = 64,
   parameter logic [15:0] BLOCK_COUNT_RST = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [31:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] core_data_in,
   output logic         core_start,
   input  logic         core_end_comp,
   input  logic [127:0] core_data_out,
   output logic         core_disable,
   input  logic         abort,
   output logic         busy,
   output logic         timeout_err,
   output logic [15:0]  block_count
);

   localparam logic [9:0] TMR_LAST = 10'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_START  = 2'd1,
      S_WAIT   = 2'd2,
      S_UNLOAD = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     w_cnt_q, w_cnt_d;
   logic [1:0]     r_cnt_q, r_cnt_d;
   logic [9:0]     tmr_q, tmr_d;
   logic [127:0]   blk_q;
   logic [127:0]   res_q;
   logic [15:0]    blk_cnt_q;
   logic           tmo_err_q;
   logic           dis_q, dis_d;
   logic           wr_word;
   logic           cap_res;
   logic           set_tmo;
   logic           cnt_inc;

   // Abort outranks everything, including a completion or a final output handshake.
   always_comb begin
      state_d = state_q;
      w_cnt_d = w_cnt_q;
      r_cnt_d = r_cnt_q;
      tmr_d   = tmr_q;
      dis_d   = 1'b0;
      wr_word = 1'b0;
      cap_res = 1'b0;
      set_tmo = 1'b0;
      cnt_inc = 1'b0;
      if (abort) begin
         state_d = S_LOAD;
         w_cnt_d = 2'd0;
         r_cnt_d = 2'd0;
         dis_d   = 1'b1;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  wr_word = 1'b1;
                  w_cnt_d = w_cnt_q + 2'd1;
                  if (w_cnt_q == 2'd3) state_d = S_START;
               end
            end
            S_START: begin
               tmr_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               tmr_d = tmr_q + 10'd1;
               if (core_end_comp) begin
                  cap_res = 1'b1;
                  r_cnt_d = 2'd0;
                  state_d = S_UNLOAD;
               end else if (tmr_q == TMR_LAST) begin
                  set_tmo = 1'b1;
                  dis_d   = 1'b1;
                  w_cnt_d = 2'd0;
                  state_d = S_LOAD;
               end
            end
            S_UNLOAD: begin
               if (out_ready) begin
                  r_cnt_d = r_cnt_q + 2'd1;
                  if (r_cnt_q == 2'd3) begin
                     cnt_inc = 1'b1;
                     state_d = S_LOAD;
                  end
               end
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_LOAD;
         w_cnt_q   <= 2'd0;
         r_cnt_q   <= 2'd0;
         tmr_q     <= '0;
         dis_q     <= 1'b0;
         tmo_err_q <= 1'b0;
         blk_cnt_q <= BLOCK_COUNT_RST;
      end else begin
         state_q <= state_d;
         w_cnt_q <= w_cnt_d;
         r_cnt_q <= r_cnt_d;
         tmr_q   <= tmr_d;
         dis_q   <= dis_d;
         if (abort)        tmo_err_q <= 1'b0;
         else if (set_tmo) tmo_err_q <= 1'b1;
         if (cnt_inc) blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   // Word 0 lands in the most significant lane of the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q <= '0;
         res_q <= '0;
      end else begin
         if (wr_word) begin
            case (w_cnt_q)
               2'd0:    blk_q[127:96] <= in_data;
               2'd1:    blk_q[95:64]  <= in_data;
               2'd2:    blk_q[63:32]  <= in_data;
               default: blk_q[31:0]   <= in_data;
            endcase
         end
         if (cap_res) res_q <= core_data_out;
      end
   end

   always_comb begin
      out_data = res_q[127:96];
      case (r_cnt_q)
         2'd0:    out_data = res_q[127:96];
         2'd1:    out_data = res_q[95:64];
         2'd2:    out_data = res_q[63:32];
         default: out_data = res_q[31:0];
      endcase
   end

   // State sits at LOAD during reset, so in_ready is gated by rst_n directly.
   assign in_ready     = rst_n && (state_q == S_LOAD);
   assign out_valid    = (state_q == S_UNLOAD);
   assign core_start   = (state_q == S_START);
   assign core_disable = dis_q;
   assign core_data_in = blk_q;
   assign busy         = (state_q != S_LOAD) || (w_cnt_q != 2'd0);
   assign timeout_err  = tmo_err_q;
   assign block_count  = blk_cnt_q;

endmodule
